mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit that sits directly downstream of the 32-entry register file.
- Consumes the two read-port operands and computes MIPS MULT/MULTU/DIV/DIVU into dedicated Hi/Lo registers, one bit per cycle.
- Also supports MTHI/MTLO writes.
- Hi/Lo feed the writeback mux for MFHI/MFLO; Busy stalls the controller.

Parameters:
WIDTH, 32, operand/Hi/Lo width; iteration count equals WIDTH

Ports:
Clock  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-low reset
A  input  WIDTH  operand 1 (multiplicand/dividend; MTHI/MTLO source), from ReadData1
B  input  WIDTH  operand 2 (multiplier/divisor), from ReadData2
Op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
Start  input  1  request operation; sampled on rising edge
WriteHi  input  1  MTHI: Hi <= A
WriteLo  input  1  MTLO: Lo <= A
Hi  output  WIDTH  product high word / remainder
Lo  output  WIDTH  product low word / quotient
Busy  output  1  operation in progress
Done  output  1  one-cycle pulse when Hi/Lo updated by an operation
DivZero  output  1  last division had B==0

Behaviour:
- Reset (Reset==0, async):
  - Hi=0, Lo=0, Busy=0, Done=0, DivZero=0.
  - State IDLE, iteration counter 0.
  - Aborts any operation in flight; no partial result reaches Hi/Lo.
- States: IDLE, RUN, FIX.
- IDLE, Start=1 at edge E0:
  - Latch |A|, |B| (abs applied only for signed ops), result signs and Op.
  - DivZero<=0, counter<=0, Busy<=1, state<=RUN.
- RUN: one iteration per edge, E1..E_WIDTH.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; remainder WIDTH+1 bits internally.
  - At the edge where counter==WIDTH-1: state<=FIX.
- FIX (edge E_WIDTH+1):
  - Apply sign correction and load Hi/Lo.
  - Done<=1 for exactly one cycle, Busy<=0, state<=IDLE.
- Latency: result visible and Done high in the cycle after edge E_WIDTH+1, i.e. 33 cycles after the Start edge for WIDTH=32. Busy is high for 33 cycles.
- MULT/MULTU: {Hi,Lo} = full 2*WIDTH product, two's-complement for MULT.
- DIV/DIVU:
  - Lo = quotient, truncated toward zero.
  - Hi = remainder, sign follows dividend.
  - Overflow case 0x80000000 / -1 gives Lo=0x80000000, Hi=0 (natural result of the abs/negate datapath, no special case).
- Divide by zero (Op[1]=1, B==0 at Start):
  - State goes IDLE->FIX directly; no iterations.
  - Hi/Lo unchanged.
  - DivZero<=1 at the FIX edge; Done pulses in the cycle after E1.
  - DivZero holds until the next accepted Start or Reset.
- Start while Busy=1: ignored, no queuing.
- WriteHi/WriteLo:
  - Take effect at the edge only in IDLE with Start=0.
  - Both high: both Hi and Lo load A.
  - Ignored while Busy, and ignored in a cycle where Start is accepted (Start has priority).
  - Never assert Done.
- Operands A/B/Op may change freely after E0; internal copies are used.
- Done is never asserted in two consecutive cycles.
- Back-to-back: Start may be asserted in the Done cycle; it is accepted at that edge since the state is IDLE.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF, Start pulse -> Busy high 33 cycles; Done 33 cycles after Start edge; Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT A=0xFFFFFFFD (-3) B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. Then DIV A=0xFFFFFFF9 (-7) B=2, issued in the Done cycle -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIVU A=100 B=0 with Hi=0x11, Lo=0x22 preloaded via WriteHi/WriteLo -> Done one cycle after E1, DivZero=1, Hi=0x11, Lo=0x22. Next MULTU 2*3 clears DivZero -> Lo=6, Hi=0.
- DIV A=0x80000000 B=0xFFFFFFFF -> Lo=0x80000000, Hi=0. DIVU 7/3 -> Lo=2, Hi=1.
- During a MULTU: Start with different operands, and WriteHi, at cycle 10 -> both ignored; final result is for the original operands.
- Reset low at cycle 15 of a DIV -> Hi=Lo=0, Busy=0 immediately, Done never pulses. After release, a new MULTU 4*4 gives Lo=16.

Source files
------------

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative MIPS MULT/MULTU/DIV/DIVU unit with Hi/Lo registers,
//            one bit per cycle, plus MTHI/MTLO writes.
// Revision : 1.0  initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_op,
  input  logic             i_start,
  input  logic             i_write_hi,
  input  logic             i_write_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero
);

  localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_fix  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [c_cnt_w-1:0] r_count;
  logic               r_is_div;
  logic               r_skip;      // divide by zero: no result load
  logic               r_neg_lo;    // product / quotient sign
  logic               r_neg_hi;    // remainder sign (dividend sign)
  logic [WIDTH-1:0]   r_rem;       // product high half / partial remainder
  logic [WIDTH-1:0]   r_quo;       // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0]   r_opnd;      // |multiplicand| or |divisor|

  logic               w_accept;
  logic               w_iter;
  logic               w_finish;
  logic               w_move_to;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_div_zero_req;

  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_signed;
  logic [WIDTH-1:0]   w_quo_signed;
  logic [WIDTH-1:0]   w_rem_signed;

  // Operand conditioning: magnitudes only taken for the signed ops (op[0]).
  assign w_neg_a        = i_op[0] & i_a[WIDTH-1];
  assign w_neg_b        = i_op[0] & i_b[WIDTH-1];
  assign w_abs_a        = w_neg_a ? -i_a : i_a;
  assign w_abs_b        = w_neg_b ? -i_b : i_b;
  assign w_div_zero_req = i_op[1] & (i_b == '0);

  // Shift-add step: add multiplicand into the high half, shift the pair right.
  assign w_mul_sum = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_opnd} : '0);

  // Restoring divide step on a WIDTH+1 bit shifted remainder.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_opnd};
  assign w_ge    = ~w_diff[WIDTH+1];

  assign w_prod        = {r_rem, r_quo};
  assign w_prod_signed = r_neg_lo ? -w_prod : w_prod;
  assign w_quo_signed  = r_neg_lo ? -r_quo : r_quo;
  assign w_rem_signed  = r_neg_hi ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_idle;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:  if (i_start) w_next_state = w_div_zero_req ? c_fix : c_run;
      c_run:   if (r_count == c_cnt_last) w_next_state = c_fix;
      c_fix:   w_next_state = c_idle;
      default: w_next_state = c_idle;
    endcase
  end

  always_comb begin
    o_busy    = (r_state != c_idle);
    w_accept  = (r_state == c_idle) & i_start;
    w_iter    = (r_state == c_run);
    w_finish  = (r_state == c_fix);
    w_move_to = (r_state == c_idle) & ~i_start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_is_div   <= 1'b0;
      r_skip     <= 1'b0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_opnd     <= '0;
      o_hi       <= '0;
      o_lo       <= '0;
      o_done     <= 1'b0;
      o_div_zero <= 1'b0;
    end else begin
      o_done <= w_finish;
      if (w_accept) begin
        r_count    <= '0;
        r_is_div   <= i_op[1];
        r_skip     <= w_div_zero_req;
        r_neg_lo   <= w_neg_a ^ w_neg_b;
        r_neg_hi   <= w_neg_a;
        r_rem      <= '0;
        o_div_zero <= 1'b0;
        if (i_op[1]) begin
          r_quo  <= w_abs_a;
          r_opnd <= w_abs_b;
        end else begin
          r_quo  <= w_abs_b;
          r_opnd <= w_abs_a;
        end
      end else if (w_iter) begin
        r_count <= r_count + c_cnt_one;
        if (r_is_div) begin
          r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
        end else begin
          r_rem <= w_mul_sum[WIDTH:1];
          r_quo <= {w_mul_sum[0], r_quo[WIDTH-1:1]};
        end
      end else if (w_finish) begin
        if (r_skip) begin
          o_div_zero <= 1'b1;
        end else if (r_is_div) begin
          o_hi <= w_rem_signed;
          o_lo <= w_quo_signed;
        end else begin
          o_hi <= w_prod_signed[2*WIDTH-1:WIDTH];
          o_lo <= w_prod_signed[WIDTH-1:0];
        end
      end else if (w_move_to) begin
        if (i_write_hi) o_hi <= i_a;
        if (i_write_lo) o_lo <= i_a;
      end
    end
  end

endmodule
`default_nettype wire
